// File: rtl/pos_cell_access_if.sv
// rtl/pos_cell_access_if.sv - request, stream and RAM port bundle of the position cell controller
interface pos_cell_access_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_start;
    logic                  rd_busy;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_pid;
    logic                  rd_done;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ack;
    logic                  wr_err;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;

    modport master (
        output rd_start, wr_req, wr_addr, wr_data, mem_q,
        input  rd_busy, out_valid, out_data, out_pid, rd_done, wr_ack, wr_err,
        input  mem_address, mem_data, mem_rden, mem_wren
    );

    modport slave (
        input  rd_start, wr_req, wr_addr, wr_data, mem_q,
        output rd_busy, out_valid, out_data, out_pid, rd_done, wr_ack, wr_err,
        output mem_address, mem_data, mem_rden, mem_wren
    );
endinterface

// File: rtl/pos_cell_access_ctrl.sv
// rtl/pos_cell_access_ctrl.sv - cell position RAM access: whole-cell read stream and motion-update writes
module pos_cell_access_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    pos_cell_access_if.slave io_bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_PID = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_CNT_RD, S_CNT_WAIT, S_STREAM, S_DRAIN} state_t;

    state_t                r_state, w_next_state;
    logic                  r_wait;
    logic [ADDR_WIDTH-1:0] r_n;
    logic                  r_iss_v, r_p1_v, r_out_valid;
    logic [ADDR_WIDTH-1:0] r_p1_pid, r_out_pid;
    logic                  r_rd_busy, r_rd_done, r_wr_ack, r_wr_err;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_mem_rden, r_mem_wren;

    logic                  w_iss_v, w_rd_done, w_wr_ack, w_wr_err;
    logic [ADDR_WIDTH-1:0] w_mem_address;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic                  w_mem_rden, w_mem_wren;
    logic [ADDR_WIDTH-1:0] w_cnt, w_issue_addr;
    logic                  w_wr_bad;

    // Particle count from RAM word 0, clamped to the last valid particle slot
    assign w_cnt        = (io_bus.mem_q[ADDR_WIDTH-1:0] > LAST_PID) ? LAST_PID
                                                                    : io_bus.mem_q[ADDR_WIDTH-1:0];
    assign w_issue_addr = r_mem_address + ADDR_WIDTH'(1);
    assign w_wr_bad     = io_bus.wr_addr > LAST_PID;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_wait        <= 1'b0;
            r_n           <= '0;
            r_iss_v       <= 1'b0;
            r_p1_v        <= 1'b0;
            r_p1_pid      <= '0;
            r_out_valid   <= 1'b0;
            r_out_pid     <= '0;
            r_rd_busy     <= 1'b0;
            r_rd_done     <= 1'b0;
            r_wr_ack      <= 1'b0;
            r_wr_err      <= 1'b0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_rden    <= 1'b0;
            r_mem_wren    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_wait        <= (r_state == S_CNT_WAIT) && !r_wait;
            if ((r_state == S_CNT_WAIT) && r_wait) r_n <= w_cnt;
            // Issue flag and pid shadow the two-cycle RAM read latency
            r_iss_v       <= w_iss_v;
            r_p1_v        <= r_iss_v;
            r_p1_pid      <= r_mem_address;
            r_out_valid   <= r_p1_v;
            r_out_pid     <= r_p1_v ? r_p1_pid : '0;
            r_rd_busy     <= (w_next_state != S_IDLE);
            r_rd_done     <= w_rd_done;
            r_wr_ack      <= w_wr_ack;
            r_wr_err      <= w_wr_err;
            r_mem_address <= w_mem_address;
            r_mem_data    <= w_mem_data;
            r_mem_rden    <= w_mem_rden;
            r_mem_wren    <= w_mem_wren;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (io_bus.rd_start) w_next_state = S_CNT_RD;
            S_CNT_RD:   w_next_state = S_CNT_WAIT;
            S_CNT_WAIT: if (r_wait) w_next_state = (w_cnt > ADDR_WIDTH'(1)) ? S_STREAM : S_DRAIN;
            S_STREAM:   if (w_issue_addr == r_n) w_next_state = S_DRAIN;
            S_DRAIN:    if (r_rd_done) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_iss_v       = 1'b0;
        w_rd_done     = 1'b0;
        w_wr_ack      = 1'b0;
        w_wr_err      = 1'b0;
        w_mem_address = '0;
        w_mem_data    = '0;
        w_mem_rden    = 1'b0;
        w_mem_wren    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.rd_start) begin
                    w_mem_rden = 1'b1;
                end else if (io_bus.wr_req) begin
                    w_wr_ack = 1'b1;
                    w_wr_err = w_wr_bad;
                    if (!w_wr_bad) begin
                        w_mem_wren    = 1'b1;
                        w_mem_address = io_bus.wr_addr;
                        w_mem_data    = io_bus.wr_data;
                    end
                end
            end
            S_CNT_WAIT: begin
                if (r_wait) begin
                    if (w_cnt == '0) begin
                        w_rd_done = 1'b1;
                    end else begin
                        w_iss_v       = 1'b1;
                        w_mem_rden    = 1'b1;
                        w_mem_address = ADDR_WIDTH'(1);
                    end
                end
            end
            S_STREAM: begin
                w_iss_v       = 1'b1;
                w_mem_rden    = 1'b1;
                w_mem_address = w_issue_addr;
            end
            // Last particle leaves the pipe when stage 1 is full and nothing follows it
            S_DRAIN:  w_rd_done = r_p1_v && !r_iss_v && !r_rd_done;
            default:  ;
        endcase
    end

    assign io_bus.rd_busy     = r_rd_busy;
    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_pid     = r_out_pid;
    assign io_bus.out_data    = io_bus.mem_q;
    assign io_bus.rd_done     = r_rd_done;
    assign io_bus.wr_ack      = r_wr_ack;
    assign io_bus.wr_err      = r_wr_err;
    assign io_bus.mem_address = r_mem_address;
    assign io_bus.mem_data    = r_mem_data;
    assign io_bus.mem_rden    = r_mem_rden;
    assign io_bus.mem_wren    = r_mem_wren;
endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// tb/tb_pos_cell_access_ctrl.sv - directed self-checking bench for pos_cell_access_ctrl
module tb_pos_cell_access_ctrl;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pos_cell_access_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pos_cell_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    // RAM model with two-cycle read latency
    logic [DW-1:0] ram     [0:PN-1];
    logic [DW-1:0] exp_mem [0:PN-1];
    logic [DW-1:0] q1;

    always @(posedge clk) begin
        if (bus.mem_wren && int'(bus.mem_address) < PN) ram[bus.mem_address] <= bus.mem_data;
        q1         <= (int'(bus.mem_address) < PN) ? ram[bus.mem_address] : '0;
        bus.mem_q  <= q1;
    end

    function automatic logic [DW-1:0] pat(input int k);
        return {32'(k) + 32'h3000_0000, 32'(k) + 32'h2000_0000, 32'(k) + 32'h1000_0000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic write_one(input int addr, input logic [DW-1:0] data, input bit exp_err);
        bus.wr_req  = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        tick();
        chk("wr_ack", DW'(bus.wr_ack), DW'(1));
        chk("wr_err", DW'(bus.wr_err), DW'(exp_err));
        chk("wr_wren", DW'(bus.mem_wren), DW'(!exp_err));
        chk("wr_rden", DW'(bus.mem_rden), '0);
        if (!exp_err) begin
            chk("wr_addr", DW'(bus.mem_address), DW'(addr));
            chk("wr_data", bus.mem_data, data);
            exp_mem[addr] = data;
        end
        bus.wr_req = 1'b0;
    endtask

    // Starts a stream in the current cycle t and checks cycles t+1 .. t+last+1
    task automatic run_stream(input int n, input bit poke);
        int  last;
        bit  e_valid, e_rden;
        last = (n == 0) ? 4 : n + 5;
        bus.rd_start = 1'b1;
        for (int d = 1; d <= last + 1; d++) begin
            tick();
            bus.rd_start = poke && (d == 2);
            e_valid = (n > 0) && (d >= 6) && (d <= n + 5);
            e_rden  = (d == 1) || ((n > 0) && (d >= 4) && (d <= n + 3));
            chk("rd_busy", DW'(bus.rd_busy), DW'(d <= last));
            chk("rd_done", DW'(bus.rd_done), DW'(d == last));
            chk("out_valid", DW'(bus.out_valid), DW'(e_valid));
            chk("mem_rden", DW'(bus.mem_rden), DW'(e_rden));
            chk("mem_wren", DW'(bus.mem_wren), '0);
            chk("wr_ack_stall", DW'(bus.wr_ack), '0);
            if (e_valid) begin
                chk("out_pid", DW'(bus.out_pid), DW'(d - 5));
                chk("out_data", bus.out_data, exp_mem[d - 5]);
            end
            if (e_rden) chk("rd_addr", DW'(bus.mem_address), DW'((d == 1) ? 0 : d - 3));
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, DW'(bus.rd_busy), '0);
        chk({tag, "_valid"}, DW'(bus.out_valid), '0);
        chk({tag, "_pid"}, DW'(bus.out_pid), '0);
        chk({tag, "_done"}, DW'(bus.rd_done), '0);
        chk({tag, "_ack"}, DW'(bus.wr_ack), '0);
        chk({tag, "_err"}, DW'(bus.wr_err), '0);
        chk({tag, "_rden"}, DW'(bus.mem_rden), '0);
        chk({tag, "_wren"}, DW'(bus.mem_wren), '0);
        chk({tag, "_addr"}, DW'(bus.mem_address), '0);
        chk({tag, "_mdata"}, bus.mem_data, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.rd_start = 1'b0;
        bus.wr_req   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        repeat (3) tick();
        chk_quiet("reset");

        // Load the cell through the write port, back to back, starting on the first edge out of reset
        rst_n = 1'b1;
        write_one(0, DW'(5), 1'b0);
        for (int k = 1; k < PN; k++) write_one(k, pat(k), 1'b0);
        tick();
        chk_quiet("idle");

        // Five particles, with a second rd_start while busy that must be ignored
        run_stream(5, 1'b1);
        chk_quiet("after5");

        // Empty cell
        write_one(0, DW'(0), 1'b0);
        run_stream(0, 1'b0);

        // Oversized count clamps to 219
        write_one(0, DW'(250), 1'b0);
        run_stream(219, 1'b0);

        // Read and write requested together: read wins, write held until back in IDLE
        write_one(0, DW'(5), 1'b0);
        bus.wr_req  = 1'b1;
        bus.wr_addr = AW'(3);
        bus.wr_data = 96'hABCD_0000_1234_5678_9ABC_DEF0;
        run_stream(5, 1'b0);
        tick();
        chk("held_ack", DW'(bus.wr_ack), DW'(1));
        chk("held_wren", DW'(bus.mem_wren), DW'(1));
        chk("held_addr", DW'(bus.mem_address), DW'(3));
        chk("held_data", bus.mem_data, 96'hABCD_0000_1234_5678_9ABC_DEF0);
        bus.wr_req = 1'b0;
        exp_mem[3] = 96'hABCD_0000_1234_5678_9ABC_DEF0;
        tick();
        chk("held_once", DW'(bus.wr_ack), '0);
        run_stream(5, 1'b0);

        // Out-of-range write
        write_one(230, pat(230), 1'b1);
        tick();
        chk("err_once", DW'(bus.wr_err), '0);

        // Reset in the middle of a ten-particle stream
        write_one(0, DW'(10), 1'b0);
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        repeat (6) tick();
        chk("pre_rst_valid", DW'(bus.out_valid), DW'(1));
        rst_n = 1'b0;
        tick();
        chk_quiet("midrst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_done", DW'(bus.rd_done), '0);
            chk("midrst_valid", DW'(bus.out_valid), '0);
        end
        rst_n = 1'b1;
        run_stream(10, 1'b0);
        chk_quiet("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
